mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
- Pipelined unsigned shift-add multiplier: the DUT end of the multiplier verification interface (clk, rstn, Xin, Yin, i_valid, Zout, o_valid).
- Accepts one operand pair per cycle, with no backpressure.
- Returns the full-width product a fixed number of cycles later.
- Drivers sample outputs at posedge; monitors sample at negedge.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- BPS, 2, multiplier bits consumed per stage; WIDTH % BPS must be 0 (elaboration-time assertion).
- STAGES, WIDTH/BPS (derived localparam, not overridable), pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock, all flops on posedge.
- rstn  in  1  asynchronous active-low reset.
- Xin  in  WIDTH  multiplicand, sampled when i_valid=1.
- Yin  in  WIDTH  multiplier, sampled when i_valid=1.
- i_valid  in  1  operand pair valid this cycle.
- Zout  out  2*WIDTH  product Xin*Yin.
- o_valid  out  1  Zout valid this cycle.

Behaviour:
- Reset:
  - Asynchronous on rstn=0: o_valid=0, Zout=0, all stage valid bits=0, all stage data regs=0.
  - Release is effective at the first posedge with rstn=1.
- Acceptance: every posedge with i_valid=1 captures Xin/Yin into stage 0. No ready signal; inputs are never dropped or stalled.
- Latency:
  - A pair captured at edge N produces o_valid=1 with its Zout after edge N+STAGES.
  - Default is 4 cycles.
  - Throughput is 1 per cycle; order is preserved.
- Stage k (0..STAGES-1) carries valid_k, mcand (WIDTH), mplier residue (WIDTH), and partial sum (2*WIDTH).
  - Each stage adds (mcand * mplier[BPS-1:0]) << (k*BPS) to the partial sum, then shifts the mplier residue right by BPS.
- Arithmetic: unsigned, full precision, 2*WIDTH partial sum. No overflow is possible; carries must not be truncated.
- Bubbles:
  - valid_k propagates every cycle regardless of data.
  - Stage data regs load only when the incoming valid=1 (clock-gate friendly) and otherwise hold.
- Output hold: Zout updates only on a valid result. When o_valid=0, Zout holds the last valid product (0 after reset).
- Simultaneous events: capture in stage 0 and result in the last stage in the same cycle is the normal case and needs no arbitration.
- Reset mid-operation: all in-flight results are discarded. o_valid stays 0 until new inputs traverse the full STAGES latency.
- X-handling: Xin/Yin are don't-care when i_valid=0 and must not propagate into Zout. i_valid=X is a bench error; assert on it in simulation.

Decomposition:
- Package mul_pkg:
  - Localparams WIDTH_DEF=8, BPS_DEF=2.
  - Typedefs operand_t (logic [WIDTH-1:0]) and product_t (logic [2*WIDTH-1:0]).
  - Stage struct stage_t {valid, mcand, mplier, psum}.
- Sub-module mul_stage:
  - Parameterised by stage index K, WIDTH and BPS.
  - One registered stage.
  - mul_pipe instantiates STAGES copies in a generate loop.

Test Plan:
- Single pair: reset, then Xin=0x0C, Yin=0x0D with i_valid=1 for 1 cycle -> o_valid=1 exactly 4 cycles later with Zout=0x009C, then o_valid=0 with Zout holding 0x009C.
- Corners back-to-back: (0xFF,0xFF), (0x00,0xA5), (0x80,0x02), (0x01,0xFF) on consecutive cycles -> Zout=0xFE01, 0x0000, 0x0100, 0x00FF on 4 consecutive o_valid cycles.
- Bubbles: valid pattern 1,0,1,1,0 with pairs (3,5) and (7,9),(0x10,0x10) -> o_valid pattern 1,0,1,1,0 delayed by 4 with Zout=0x000F, 0x003F, 0x0100; Zout unchanged during bubble cycles.
- Reset mid-flight: issue 3 pairs, assert rstn=0 asynchronously between edges 2 and 3 -> o_valid=0 and Zout=0 immediately; no stale result after release.
- Random soak: 10k random pairs with ~70% valid density -> scoreboard (negedge monitor) matches Xin*Yin in order with zero mismatches.
- Parameter variant: WIDTH=8, BPS=1 (8 stages) and BPS=8 (1 stage), pair (0xFF,0xFF) -> 0xFE01 at latency 8 and 1 respectively.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared defaults and types for the pipelined unsigned shift-add multiplier.
package mul_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned BPS_DEF   = 2;

    typedef logic [WIDTH_DEF-1:0]   operand_t;
    typedef logic [2*WIDTH_DEF-1:0] product_t;

    typedef struct packed {
        logic     valid;
        operand_t mcand;
        operand_t mplier;
        product_t psum;
    } stage_t;

endpackage

// File: rtl/mul_stage.sv
// One registered multiplier stage: adds mcand times the low BPS multiplier bits,
// weighted by the stage position, then retires those bits from the residue.
module mul_stage
    import mul_pkg::*;
#(
    parameter int unsigned K     = 0,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned BPS   = BPS_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               src_valid,
    input  logic [WIDTH-1:0]   src_mcand,
    input  logic [WIDTH-1:0]   src_mplier,
    input  logic [2*WIDTH-1:0] src_psum,
    output logic               valid,
    output logic [WIDTH-1:0]   mcand,
    output logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] psum
);

    logic [2*WIDTH-1:0] term;

    always_comb begin
        term = ({{WIDTH{1'b0}}, src_mcand} * {{(2*WIDTH-BPS){1'b0}}, src_mplier[BPS-1:0]}) << (K*BPS);
    end

    // Valid advances every cycle; data only loads behind a valid token.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid  <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            psum   <= '0;
        end else begin
            valid <= src_valid;
            if (src_valid) begin
                mcand  <= src_mcand;
                mplier <= src_mplier >> BPS;
                psum   <= src_psum + term;
            end
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined unsigned shift-add multiplier: one operand pair per cycle,
// full-width product STAGES cycles later, order preserved.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned BPS   = BPS_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   Xin,
    input  logic [WIDTH-1:0]   Yin,
    input  logic               i_valid,
    output logic [2*WIDTH-1:0] Zout,
    output logic               o_valid
);

    localparam int unsigned STAGES = WIDTH / BPS;

    if (WIDTH % BPS != 0) begin : g_bad_bps
        $error("mul_pipe: WIDTH must be a multiple of BPS");
    end

    logic               v  [STAGES+1];
    logic [WIDTH-1:0]   mc [STAGES+1];
    logic [WIDTH-1:0]   mp [STAGES+1];
    logic [2*WIDTH-1:0] ps [STAGES+1];

    assign v[0]  = i_valid;
    assign mc[0] = Xin;
    assign mp[0] = Yin;
    assign ps[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mul_stage #(
            .K     (k),
            .WIDTH (WIDTH),
            .BPS   (BPS)
        ) u_stage (
            .clk        (clk),
            .rstn       (rstn),
            .src_valid  (v[k]),
            .src_mcand  (mc[k]),
            .src_mplier (mp[k]),
            .src_psum   (ps[k]),
            .valid      (v[k+1]),
            .mcand      (mc[k+1]),
            .mplier     (mp[k+1]),
            .psum       (ps[k+1])
        );
    end

    // The final stage's operand copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mc[STAGES], mp[STAGES]};

    // Output register: Zout holds the last valid product across bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            Zout    <= '0;
        end else begin
            o_valid <= v[STAGES];
            if (v[STAGES]) begin
                Zout <= ps[STAGES];
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) !$isunknown(i_valid))
        else $error("mul_pipe: i_valid is unknown");

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: cycle-accurate product model with per-cycle compare,
// directed literal sequences, mid-flight reset, random soak and BPS variants.
module tb_mul_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  x, y;
    logic        iv;
    logic [15:0] z;
    logic        ov;

    logic [7:0]  x1, y1, x8, y8;
    logic        iv1, iv8;
    logic [15:0] z1, z8;
    logic        ov1, ov8;

    int checks = 0;
    int failures = 0;
    bit run_chk = 0;

    mul_pipe #(.WIDTH(8), .BPS(2)) dut (
        .clk(clk), .rstn(rstn), .Xin(x), .Yin(y), .i_valid(iv), .Zout(z), .o_valid(ov)
    );
    mul_pipe #(.WIDTH(8), .BPS(1)) dut_b1 (
        .clk(clk), .rstn(rstn), .Xin(x1), .Yin(y1), .i_valid(iv1), .Zout(z1), .o_valid(ov1)
    );
    mul_pipe #(.WIDTH(8), .BPS(8)) dut_b8 (
        .clk(clk), .rstn(rstn), .Xin(x8), .Yin(y8), .i_valid(iv8), .Zout(z8), .o_valid(ov8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted pair is due LAT edges after capture, in order.
    typedef struct { int due; logic [15:0] p; } item_t;
    item_t       q[$];
    int          cyc;
    logic        exp_v;
    logic [15:0] exp_z;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            cyc   <= 0;
            exp_v <= 1'b0;
            exp_z <= '0;
        end else begin
            int n;
            item_t it;
            n = cyc + 1;
            cyc <= n;
            if (iv === 1'b1) begin
                it.due = n + LAT;
                it.p   = 16'(x) * 16'(y);
                q.push_back(it);
            end
            if (q.size() > 0 && q[0].due == n) begin
                exp_v <= 1'b1;
                exp_z <= q[0].p;
                void'(q.pop_front());
            end else begin
                exp_v <= 1'b0;
            end
        end
    end

    logic [15:0] obs[$];
    logic [15:0] mdl[$];
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (run_chk) begin
            chk("o_valid", 32'(ov), 32'(exp_v));
            chk("Zout", 32'(z), 32'(exp_z));
            if (ov) obs.push_back(z);
            if (exp_v) mdl.push_back(exp_z);
        end
    end

    task automatic check_seq(input string name);
        chk({name, "_dut_count"}, obs.size(), exp_q.size());
        chk({name, "_model_count"}, mdl.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({name, "_dut"}, (i < obs.size()) ? 32'(obs[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
            chk({name, "_model"}, (i < mdl.size()) ? 32'(mdl[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        end
        obs.delete();
        mdl.delete();
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        iv = v; x = a; y = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            iv = 1'b0; x = 8'($urandom); y = 8'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, l1, l8;
        logic [15:0] c1, c8;
        rstn = 1'b0;
        iv = 1'b0; x = '0; y = '0;
        iv1 = 1'b0; x1 = '0; y1 = '0;
        iv8 = 1'b0; x8 = '0; y8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_o_valid", 32'(ov), 0);
        chk("reset_Zout", 32'(z), 0);
        rstn = 1'b1;
        run_chk = 1;

        // Single pair with exact latency and hold afterwards
        obs.delete(); mdl.delete();
        drive(1'b1, 8'h0C, 8'h0D);
        iv = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ov) begin lat = c; break; end
        end
        chk("single_latency", 32'(lat), 4);
        chk("single_Zout", 32'(z), 32'h009C);
        @(negedge clk);
        chk("single_after_o_valid", 32'(ov), 0);
        chk("single_hold_Zout", 32'(z), 32'h009C);
        idle(2);
        exp_q = '{16'h009C};
        check_seq("single");

        // Corner operands back-to-back
        drive(1'b1, 8'hFF, 8'hFF);
        drive(1'b1, 8'h00, 8'hA5);
        drive(1'b1, 8'h80, 8'h02);
        drive(1'b1, 8'h01, 8'hFF);
        idle(6);
        exp_q = '{16'hFE01, 16'h0000, 16'h0100, 16'h00FF};
        check_seq("corners");

        // Bubbles in the valid stream
        drive(1'b1, 8'd3, 8'd5);
        drive(1'b0, 8'hAA, 8'h55);
        drive(1'b1, 8'd7, 8'd9);
        drive(1'b1, 8'h10, 8'h10);
        drive(1'b0, 8'h33, 8'hCC);
        idle(6);
        exp_q = '{16'h000F, 16'h003F, 16'h0100};
        check_seq("bubbles");

        // Reset while three pairs are in flight
        drive(1'b1, 8'h11, 8'h22);
        drive(1'b1, 8'h33, 8'h44);
        iv = 1'b1; x = 8'h55; y = 8'h66;
        #2 rstn = 1'b0;
        #1;
        chk("midreset_o_valid", 32'(ov), 0);
        chk("midreset_Zout", 32'(z), 0);
        @(negedge clk);
        @(negedge clk);
        iv = 1'b0;
        rstn = 1'b1;
        idle(8);
        exp_q.delete();
        check_seq("midreset_no_stale");

        // Random soak at ~70% valid density
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom));
        end
        idle(6);
        chk("soak_drained", 32'(q.size()), 0);
        obs.delete(); mdl.delete();

        // Parameter variants: 8-stage and 1-stage pipelines
        iv1 = 1'b1; x1 = 8'hFF; y1 = 8'hFF;
        iv8 = 1'b1; x8 = 8'hFF; y8 = 8'hFF;
        @(negedge clk);
        iv1 = 1'b0; iv8 = 1'b0;
        l1 = -1; l8 = -1; c1 = '0; c8 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ov1 && l1 < 0) begin l1 = c; c1 = z1; end
            if (ov8 && l8 < 0) begin l8 = c; c8 = z8; end
        end
        chk("bps1_latency", 32'(l1), 8);
        chk("bps1_Zout", 32'(c1), 32'hFE01);
        chk("bps8_latency", 32'(l8), 1);
        chk("bps8_Zout", 32'(c8), 32'hFE01);

        run_chk = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
